controller_sequencer: RTL and testbench



---
 rtl/controller_sequencer.sv | 149 ++++++++++++++
 tb/tb_controller_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
// Iterative-datapath state sequencer: S0 idle, S1..S7 per iteration, S8 result-valid.
// Optional S8 wait timeout is compiled in with `define SEQ_TIMEOUT_EN.
module controller_sequencer #(
  parameter int unsigned ITERS   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       HOLD,
  input  logic       ABORT,
  input  logic       ACK,
  output logic [3:0] CurrentState,
  output logic [3:0] ITER_CNT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       TIMEOUT_FLAG
);

  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;

  localparam logic [3:0] S0 = 4'b0000;
  localparam logic [3:0] S1 = 4'b0001;
  localparam logic [3:0] S2 = 4'b0010;
  localparam logic [3:0] S3 = 4'b0011;
  localparam logic [3:0] S4 = 4'b0100;
  localparam logic [3:0] S5 = 4'b0101;
  localparam logic [3:0] S6 = 4'b0110;
  localparam logic [3:0] S7 = 4'b0111;
  localparam logic [3:0] S8 = 4'b1000;

  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);
  localparam logic [CW-1:0] LAST_C  = CW'(ITERS - 1);

  // Parameter range guards, evaluated at elaboration.
  if (ITERS < 1 || ITERS > 15) begin : g_iters_chk
    $error("controller_sequencer: ITERS out of range 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_chk
    $error("controller_sequencer: TIMEOUT out of range 1..255");
  end

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          to_q, to_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wait_q, wait_d;
`endif

  // Next-state and output decode; ABORT outranks illegal-state recovery and HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    to_d    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    if (ABORT) begin
      state_d = S0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S0: begin
          if (START) begin
            state_d = S1;
            cnt_d   = '0;
          end
        end
        S1, S2, S3, S4, S5, S6: begin
          if (!HOLD) state_d = state_q + 4'd1;
        end
        S7: begin
          if (!HOLD) begin
            if (cnt_q == LAST_C) begin
              state_d = S8;
              cnt_d   = ITERS_C;
`ifdef SEQ_TIMEOUT_EN
              wait_d  = '0;
`endif
            end else begin
              state_d = S1;
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        S8: begin
          if (ACK) begin
            state_d = S0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            state_d = S0;
            cnt_d   = '0;
            to_d    = 1'b1;
          end else begin
            wait_d  = wait_q + 8'd1;
          end
`endif
        end
        default: begin
          state_d = S0;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
`ifdef SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  assign CurrentState = state_q;
  assign ITER_CNT     = cnt_q;
  assign BUSY         = (state_q != S0);
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign TIMEOUT_FLAG = to_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: job-position reference model, directed and random stimulus.
module tb_controller_sequencer;

  localparam int ITERS = 4;
`ifdef SEQ_TIMEOUT_EN
  localparam int TIMEOUT = 5;
`else
  localparam int TIMEOUT = 255;
`endif
  localparam int JOBLEN = 7 * ITERS;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       HOLD = 1'b0;
  logic       ABORT = 1'b0;
  logic       ACK = 1'b0;
  logic [3:0] CurrentState;
  logic [3:0] ITER_CNT;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic       TIMEOUT_FLAG;

  controller_sequencer #(.ITERS(ITERS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD), .ABORT(ABORT), .ACK(ACK),
    .CurrentState(CurrentState), .ITER_CNT(ITER_CNT), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .TIMEOUT_FLAG(TIMEOUT_FLAG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] st;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       err;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pos = -1 idle, 0..JOBLEN-1 position inside the job, JOBLEN = result valid.
  int pos = -1;
  int wcnt = 0;
  bit err_m = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input bit rst, input bit start, input bit hold, input bit abort, input bit ack);
    exp_t e;
    bit done_m, to_m;
    @(negedge CLK);
    RST = rst; START = start; HOLD = hold; ABORT = abort; ACK = ack;
    done_m = 1'b0;
    to_m   = 1'b0;
    if (rst) begin
      pos = -1; wcnt = 0; err_m = 1'b0;
    end else if (abort) begin
      pos = -1;
    end else if (pos < 0) begin
      if (start) pos = 0;
    end else if (pos < JOBLEN) begin
      if (!hold) begin
        pos++;
        if (pos == JOBLEN) wcnt = 0;
      end
    end else begin
      if (ack) begin
        pos = -1; done_m = 1'b1;
      end
`ifdef SEQ_TIMEOUT_EN
      else begin
        wcnt++;
        if (wcnt == TIMEOUT) begin
          pos = -1; to_m = 1'b1;
        end
      end
`endif
    end
    e.st   = (pos < 0) ? 4'd0 : (pos == JOBLEN) ? 4'd8 : 4'(pos % 7 + 1);
    e.cnt  = (pos < 0) ? 4'd0 : 4'(pos / 7);
    e.busy = (pos >= 0);
    e.done = done_m;
    e.err  = err_m;
    e.to   = to_m;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a full output vector; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(CurrentState), int'(e.st));
        chk("iter_cnt", int'(ITER_CNT), int'(e.cnt));
        chk("busy", int'(BUSY), int'(e.busy));
        chk("done", int'(DONE), int'(e.done));
        chk("err", int'(ERR), int'(e.err));
        chk("timeout_flag", int'(TIMEOUT_FLAG), int'(e.to));
      end
    end
  end

  // One job from S0 with ACK held high; HOLD high on edges (hold_from, hold_from+hold_len].
  task automatic latency_job(input int hold_from, input int hold_len, input string nm);
    int edges;
    bit seen;
    bit h;
    step(0, 1, 0, 0, 1);
    edges = 1;
    @(posedge CLK); #1;
    seen = (CurrentState == 4'd8);
    while (!seen && edges < 200) begin
      h = (edges + 1 > hold_from) && (edges + 1 <= hold_from + hold_len);
      step(0, 0, h, 0, 1);
      edges++;
      @(posedge CLK); #1;
      seen = (CurrentState == 4'd8);
    end
    chk(nm, edges, JOBLEN + 1 + hold_len);
    step(0, 0, 0, 0, 1);
  endtask

  // One job, then sit in S8 for n_wait edges without ACK, then one final edge with ACK = fin_ack.
  task automatic s8_wait_job(input int n_wait, input bit fin_ack);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < JOBLEN; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < n_wait; i++) step(0, 0, $urandom_range(0, 1), 0, 0);
    step(0, 0, 0, 0, fin_ack);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0);

    latency_job(0, 0, "latency_plain");
    step(0, 0, 0, 0, 0);
    latency_job(10, 3, "latency_hold3");
    step(0, 0, 0, 0, 0);

    // Abort in S5 of the first iteration, then a clean job.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    latency_job(0, 0, "latency_after_abort");

    // Back-to-back jobs with START and ACK held; stray START/ACK mid-job are harmless.
    for (int i = 0; i < 3 * (JOBLEN + 2); i++) step(0, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(0, $urandom_range(0, 1), 0, 0, $urandom_range(0, 1));

    // Illegal code injected mid-job.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
    @(negedge CLK);
    START = 0; HOLD = 1; ABORT = 0; ACK = 0; RST = 0;
    force dut.state_q = 4'b1011;
    @(posedge CLK); #1;
    chk("err_set", int'(ERR), 1);
    release dut.state_q;
    pos = -1; wcnt = 0; err_m = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    latency_job(0, 0, "latency_with_err");
    step(0, 0, 0, 0, 0);

    s8_wait_job(TIMEOUT - 1, 1'b0);
    s8_wait_job(TIMEOUT - 1, 1'b1);
    s8_wait_job(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0));
    end
    step(0, 0, 0, 0, 0);

    repeat (3) @(posedge CLK);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
